mem_bus_arbiter: RTL and testbench

//   Shares the single external memory port between instruction fetch (IM) and

---
 rtl/mem_bus_arbiter_if.sv | 52 +++++
 rtl/mem_bus_arbiter.sv | 178 +++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_arbiter_if.sv
// Purpose: groups the fetch port, the load/store port and the external memory bus
//          that mem_bus_arbiter sits between.
// Ports:   master = arbiter side (drives port results, stalls and mem_*);
//          slave  = environment side (pipeline stages and memory bus).
interface mem_bus_arbiter_if;
    // instruction fetch port
    logic        im_req;
    logic [31:0] im_addr;
    logic        im_cancel;
    logic [31:0] im_rdata;
    logic        im_err;
    logic        im_stall;
    // load/store port
    logic        dm_req;
    logic        dm_we;
    logic [3:0]  dm_be;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_err;
    logic        dm_stall;
    // pipeline advance
    logic        pipe_adv;
    // external memory bus
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport master (
        input  im_req, im_addr, im_cancel,
        output im_rdata, im_err, im_stall,
        input  dm_req, dm_we, dm_be, dm_addr, dm_wdata,
        output dm_rdata, dm_err, dm_stall,
        input  pipe_adv,
        output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        output im_req, im_addr, im_cancel,
        input  im_rdata, im_err, im_stall,
        output dm_req, dm_we, dm_be, dm_addr, dm_wdata,
        input  dm_rdata, dm_err, dm_stall,
        output pipe_adv,
        input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Purpose: shares one external memory port between fetch (IM) and load/store (DM),
//          one bus transaction at a time, DM first; bus timeouts become port errors.
// Latency: request seen in IDLE at cycle 0, ack in cycle 1 -> stall low in cycle 2;
//          one IDLE cycle always separates two bus transactions.
// Backpressure: ports are held off with im_stall/dm_stall until their own result is
//          buffered; results stay buffered until pipe_adv consumes them.
// Ports:   clk, rst (synchronous, active-high); bus = mem_bus_arbiter_if.master
//          carrying im_* / dm_* pipeline ports, pipe_adv and the registered mem_* bus.
module mem_bus_arbiter #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    mem_bus_arbiter_if.master bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IM_BUSY = 2'd1,
        DM_BUSY = 2'd2
    } state_e;

    state_e             state_q,     state_d;
    logic               mem_req_q,   mem_req_d;
    logic               mem_we_q,    mem_we_d;
    logic [3:0]         mem_be_q,    mem_be_d;
    logic [31:0]        mem_addr_q,  mem_addr_d;
    logic [31:0]        mem_wdata_q, mem_wdata_d;
    logic               im_done_q,   im_done_d;
    logic               dm_done_q,   dm_done_d;
    logic               discard_q,   discard_d;
    logic [31:0]        im_rdata_q,  im_rdata_d;
    logic [31:0]        dm_rdata_q,  dm_rdata_d;
    logic               im_err_q,    im_err_d;
    logic               dm_err_q,    dm_err_d;
    logic [CNT_W-1:0]   cnt_q,       cnt_d;

    logic               timed_out;
    logic               xfer_end;

    assign timed_out = (cnt_q == CNT_W'(TIMEOUT - 1));

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_be_d    = mem_be_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        im_done_d   = im_done_q;
        dm_done_d   = dm_done_q;
        discard_d   = discard_q;
        im_rdata_d  = im_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        im_err_d    = im_err_q;
        dm_err_d    = dm_err_q;
        cnt_d       = cnt_q;
        xfer_end    = 1'b0;

        case (state_q)
            IDLE: begin
                // mem_ack is ignored here: a late ack after a timeout is stray.
                discard_d = 1'b0;
                if (bus.dm_req && !dm_done_q) begin
                    // DM belongs to the older instruction, so it wins.
                    state_d     = DM_BUSY;
                    mem_req_d   = 1'b1;
                    mem_we_d    = bus.dm_we;
                    mem_be_d    = bus.dm_we ? bus.dm_be : 4'hF;
                    mem_addr_d  = bus.dm_addr;
                    mem_wdata_d = bus.dm_wdata;
                    cnt_d       = '0;
                end else if (bus.im_req && !im_done_q && !bus.im_cancel) begin
                    state_d     = IM_BUSY;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_be_d    = 4'hF;
                    mem_addr_d  = bus.im_addr;
                    mem_wdata_d = '0;
                    cnt_d       = '0;
                end
            end

            IM_BUSY, DM_BUSY: begin
                if (bus.mem_ack || timed_out) begin
                    xfer_end  = 1'b1;
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    discard_d = 1'b0;
                    if (state_q == DM_BUSY) begin
                        dm_done_d = 1'b1;
                        dm_err_d  = !bus.mem_ack;
                        if (bus.mem_ack) begin
                            dm_rdata_d = bus.mem_rdata;
                        end
                    end else if (!discard_q) begin
                        im_done_d = 1'b1;
                        im_err_d  = !bus.mem_ack;
                        if (bus.mem_ack) begin
                            im_rdata_d = bus.mem_rdata;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase

        // A flush drops any buffered fetch result. A fetch still on the bus runs to
        // completion but its data is thrown away; if it ends this very edge, the
        // cleared im_done already discards it, so discard must not linger into IDLE.
        if (bus.im_cancel) begin
            im_done_d = 1'b0;
            if (state_q == IM_BUSY && !xfer_end) begin
                discard_d = 1'b1;
            end
        end

        // Pipeline consumed the results; an ack landing on the same edge is lost.
        if (bus.pipe_adv) begin
            im_done_d = 1'b0;
            dm_done_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= 4'h0;
            mem_addr_q  <= 32'h0;
            mem_wdata_q <= 32'h0;
            im_done_q   <= 1'b0;
            dm_done_q   <= 1'b0;
            discard_q   <= 1'b0;
            im_rdata_q  <= 32'h0;
            dm_rdata_q  <= 32'h0;
            im_err_q    <= 1'b0;
            dm_err_q    <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_be_q    <= mem_be_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            im_done_q   <= im_done_d;
            dm_done_q   <= dm_done_d;
            discard_q   <= discard_d;
            im_rdata_q  <= im_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            im_err_q    <= im_err_d;
            dm_err_q    <= dm_err_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.im_stall  = bus.im_req && !im_done_q;
    assign bus.dm_stall  = bus.dm_req && !dm_done_q;
    assign bus.im_rdata  = im_rdata_q;
    assign bus.im_err    = im_err_q;
    assign bus.dm_rdata  = dm_rdata_q;
    assign bus.dm_err    = dm_err_q;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_be    = mem_be_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_bus_arbiter_if bus ();

    mem_bus_arbiter #(.TIMEOUT(255), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        int          cyc;
    } txn_t;

    txn_t        exp_bus_q[$];
    txn_t        obs_bus_q[$];
    logic [31:0] exp_im_q[$];
    logic [31:0] exp_dm_q[$];

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cycle   = 0;
    int   ack_lat = 1;
    bit   ack_en  = 1'b1;
    int   unstable_cnt = 0;
    logic model_ack = 1'b0;
    logic stray_ack = 1'b0;

    assign bus.mem_ack = model_ack | stray_ack;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0040_0000) return 32'h2408_0005;
        return a ^ 32'hA5A5_5A5A;
    endfunction

    // Memory model and bus monitor: records each new transaction and acks it in
    // its ack_lat-th cycle of mem_req.
    initial begin
        txn_t cur;
        int   busy_cnt;
        logic prev_req;
        busy_cnt = 0;
        prev_req = 1'b0;
        cur = '{addr: 32'h0, we: 1'b0, be: 4'h0, wdata: 32'h0, cyc: 0};
        bus.mem_rdata = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            cycle++;
            if (bus.mem_req === 1'b1) begin
                if (!prev_req) begin
                    cur = '{addr: bus.mem_addr, we: bus.mem_we, be: bus.mem_be,
                            wdata: bus.mem_wdata, cyc: cycle};
                    obs_bus_q.push_back(cur);
                    busy_cnt = 0;
                end else if (bus.mem_addr !== cur.addr || bus.mem_we !== cur.we ||
                             bus.mem_be !== cur.be || bus.mem_wdata !== cur.wdata) begin
                    unstable_cnt++;
                end
                busy_cnt++;
                if (ack_en && busy_cnt == ack_lat) begin
                    model_ack     = 1'b1;
                    bus.mem_rdata = mem_word(bus.mem_addr);
                end else begin
                    model_ack = 1'b0;
                end
            end else begin
                model_ack = 1'b0;
                busy_cnt  = 0;
            end
            prev_req = (bus.mem_req === 1'b1);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic consume();
        bus.pipe_adv = 1'b1;
        tick();
        bus.pipe_adv = 1'b0;
        bus.im_req   = 1'b0;
        bus.dm_req   = 1'b0;
        bus.dm_we    = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.im_req = 1'b0; bus.im_addr = 32'h0; bus.im_cancel = 1'b0;
        bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_be = 4'h0;
        bus.dm_addr = 32'h0; bus.dm_wdata = 32'h0; bus.pipe_adv = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        n_tests++; if (bus.mem_req   !== 1'b0)  begin n_fail++; $display("FAIL reset_mem_req got %h want 0", bus.mem_req); end
        n_tests++; if (bus.mem_we    !== 1'b0)  begin n_fail++; $display("FAIL reset_mem_we got %h want 0", bus.mem_we); end
        n_tests++; if (bus.mem_be    !== 4'h0)  begin n_fail++; $display("FAIL reset_mem_be got %h want 0", bus.mem_be); end
        n_tests++; if (bus.mem_addr  !== 32'h0) begin n_fail++; $display("FAIL reset_mem_addr got %h want 0", bus.mem_addr); end
        n_tests++; if (bus.mem_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_mem_wdata got %h want 0", bus.mem_wdata); end
        n_tests++; if (bus.im_rdata  !== 32'h0) begin n_fail++; $display("FAIL reset_im_rdata got %h want 0", bus.im_rdata); end
        n_tests++; if (bus.dm_rdata  !== 32'h0) begin n_fail++; $display("FAIL reset_dm_rdata got %h want 0", bus.dm_rdata); end
        n_tests++; if (bus.im_err !== 1'b0 || bus.dm_err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b%b want 00", bus.im_err, bus.dm_err); end
        n_tests++; if (bus.im_stall !== 1'b0 || bus.dm_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b%b want 00", bus.im_stall, bus.dm_stall); end
    endtask

    task automatic test_fetch();
        int n;
        txn_t e, o;
        obs_bus_q.delete();
        ack_lat = 3;
        exp_bus_q.push_back('{addr: 32'h0040_0000, we: 1'b0, be: 4'hF, wdata: 32'h0, cyc: 0});
        exp_im_q.push_back(32'h2408_0005);
        bus.im_addr = 32'h0040_0000;
        bus.im_req  = 1'b1;
        #1;
        n = 0;
        while (bus.im_stall === 1'b1 && n < 50) begin n++; tick(); end
        n_tests++; if (n != 4) begin n_fail++; $display("FAIL fetch_stall_cycles got %0d want 4", n); end
        n_tests++; if (bus.im_rdata !== exp_im_q.pop_front()) begin n_fail++; $display("FAIL fetch_rdata got %h want 24080005", bus.im_rdata); end
        n_tests++; if (bus.im_err !== 1'b0) begin n_fail++; $display("FAIL fetch_err got %b want 0", bus.im_err); end
        e = exp_bus_q.pop_front();
        n_tests++;
        if (obs_bus_q.size() != 1) begin
            n_fail++; $display("FAIL fetch_bus_count got %0d want 1", obs_bus_q.size());
        end else begin
            o = obs_bus_q.pop_front();
            if (o.addr !== e.addr || o.we !== e.we || o.be !== e.be) begin
                n_fail++; $display("FAIL fetch_bus got %h/%b/%h want %h/%b/%h", o.addr, o.we, o.be, e.addr, e.we, e.be);
            end
        end
        consume();
    endtask

    task automatic test_dual();
        int n, dm_low_at;
        bit im_first;
        txn_t e, o;
        txn_t seen[2];
        obs_bus_q.delete();
        exp_bus_q.delete();
        ack_lat = 2;
        exp_bus_q.push_back('{addr: 32'h1001_0000, we: 1'b0, be: 4'hF, wdata: 32'h0, cyc: 0});
        exp_bus_q.push_back('{addr: 32'h0040_0004, we: 1'b0, be: 4'hF, wdata: 32'h0, cyc: 0});
        exp_dm_q.push_back(mem_word(32'h1001_0000));
        exp_im_q.push_back(mem_word(32'h0040_0004));
        bus.im_addr = 32'h0040_0004; bus.im_req = 1'b1;
        bus.dm_addr = 32'h1001_0000; bus.dm_we = 1'b0; bus.dm_be = 4'h0; bus.dm_req = 1'b1;
        #1;
        n = 0; dm_low_at = -1; im_first = 1'b0;
        while ((bus.im_stall === 1'b1 || bus.dm_stall === 1'b1) && n < 60) begin
            if (bus.dm_stall === 1'b0 && dm_low_at < 0) dm_low_at = n;
            if (bus.im_stall === 1'b0 && bus.dm_stall === 1'b1) im_first = 1'b1;
            n++; tick();
        end
        n_tests++; if (n != 6) begin n_fail++; $display("FAIL dual_total_stall got %0d want 6", n); end
        n_tests++; if (dm_low_at != 3 || im_first) begin n_fail++; $display("FAIL dual_dm_first got dm_low_at=%0d im_first=%b want 3/0", dm_low_at, im_first); end
        n_tests++; if (bus.dm_rdata !== exp_dm_q.pop_front()) begin n_fail++; $display("FAIL dual_dm_rdata got %h", bus.dm_rdata); end
        n_tests++; if (bus.im_rdata !== exp_im_q.pop_front()) begin n_fail++; $display("FAIL dual_im_rdata got %h", bus.im_rdata); end
        n_tests++;
        if (obs_bus_q.size() != 2) begin
            n_fail++; $display("FAIL dual_bus_count got %0d want 2", obs_bus_q.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                e = exp_bus_q.pop_front();
                o = obs_bus_q.pop_front();
                seen[i] = o;
                if (o.addr !== e.addr || o.we !== e.we || o.be !== e.be) begin
                    n_fail++; $display("FAIL dual_bus_%0d got %h/%b/%h want %h/%b/%h", i, o.addr, o.we, o.be, e.addr, e.we, e.be);
                end
            end
            n_tests++;
            if (seen[1].cyc - seen[0].cyc != 3) begin
                n_fail++; $display("FAIL dual_idle_gap got %0d want 3", seen[1].cyc - seen[0].cyc);
            end
        end
        // Both results buffered: holding the requests must not refetch either port.
        repeat (3) tick();
        n_tests++; if (obs_bus_q.size() != 0) begin n_fail++; $display("FAIL dual_no_refetch got %0d extra txns want 0", obs_bus_q.size()); end
        n_tests++; if (bus.im_stall !== 1'b0 || bus.dm_stall !== 1'b0) begin n_fail++; $display("FAIL dual_hold_stall got %b%b want 00", bus.im_stall, bus.dm_stall); end
        consume();
    endtask

    task automatic test_store();
        int n;
        txn_t e, o;
        obs_bus_q.delete();
        exp_bus_q.delete();
        unstable_cnt = 0;
        ack_lat = 5;
        exp_bus_q.push_back('{addr: 32'h1001_0008, we: 1'b1, be: 4'b0011, wdata: 32'hDEAD_BEEF, cyc: 0});
        bus.dm_addr = 32'h1001_0008; bus.dm_we = 1'b1; bus.dm_be = 4'b0011;
        bus.dm_wdata = 32'hDEAD_BEEF; bus.dm_req = 1'b1;
        #1;
        n = 0;
        while (bus.dm_stall === 1'b1 && n < 60) begin n++; tick(); end
        n_tests++; if (n != 6) begin n_fail++; $display("FAIL store_stall_cycles got %0d want 6", n); end
        n_tests++; if (bus.dm_err !== 1'b0) begin n_fail++; $display("FAIL store_err got %b want 0", bus.dm_err); end
        n_tests++; if (unstable_cnt != 0) begin n_fail++; $display("FAIL store_bus_stable got %0d changes want 0", unstable_cnt); end
        e = exp_bus_q.pop_front();
        n_tests++;
        if (obs_bus_q.size() != 1) begin
            n_fail++; $display("FAIL store_bus_count got %0d want 1", obs_bus_q.size());
        end else begin
            o = obs_bus_q.pop_front();
            if (o.addr !== e.addr || o.we !== e.we || o.be !== e.be || o.wdata !== e.wdata) begin
                n_fail++; $display("FAIL store_bus got %h/%b/%h/%h want %h/%b/%h/%h", o.addr, o.we, o.be, o.wdata, e.addr, e.we, e.be, e.wdata);
            end
        end
        consume();
    endtask

    task automatic test_timeout();
        int n;
        logic [31:0] rd_before;
        obs_bus_q.delete();
        ack_en = 1'b0;
        rd_before = bus.dm_rdata;
        bus.dm_addr = 32'h1001_0040; bus.dm_we = 1'b0; bus.dm_req = 1'b1;
        #1;
        n = 0;
        while (bus.dm_stall === 1'b1 && n < 400) begin n++; tick(); end
        n_tests++; if (n != 256) begin n_fail++; $display("FAIL timeout_stall_cycles got %0d want 256", n); end
        n_tests++; if (bus.dm_err !== 1'b1) begin n_fail++; $display("FAIL timeout_err got %b want 1", bus.dm_err); end
        n_tests++; if (bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL timeout_mem_req got %b want 0", bus.mem_req); end
        // Late ack from the bus while the arbiter sits in IDLE must be ignored.
        stray_ack = 1'b1;
        tick();
        stray_ack = 1'b0;
        tick();
        n_tests++; if (bus.dm_err !== 1'b1 || bus.dm_rdata !== rd_before) begin n_fail++; $display("FAIL stray_ack got err=%b rdata=%h want 1/%h", bus.dm_err, bus.dm_rdata, rd_before); end
        n_tests++; if (bus.mem_req !== 1'b0 || obs_bus_q.size() != 1) begin n_fail++; $display("FAIL stray_ack_bus got req=%b txns=%0d want 0/1", bus.mem_req, obs_bus_q.size()); end
        consume();
        ack_en = 1'b1;
    endtask

    task automatic test_cancel();
        int n;
        txn_t o;
        obs_bus_q.delete();
        ack_lat = 4;
        exp_im_q.push_back(mem_word(32'hBFC0_0380));
        bus.im_addr = 32'h0000_1000; bus.im_req = 1'b1;
        tick(); tick();
        bus.im_cancel = 1'b1; bus.im_addr = 32'hBFC0_0380;
        tick();
        bus.im_cancel = 1'b0;
        n = 3;
        while (bus.im_stall === 1'b1 && n < 80) begin n++; tick(); end
        n_tests++; if (n != 10) begin n_fail++; $display("FAIL cancel_stall_cycles got %0d want 10", n); end
        n_tests++; if (bus.im_rdata !== exp_im_q.pop_front()) begin n_fail++; $display("FAIL cancel_rdata got %h want %h", bus.im_rdata, mem_word(32'hBFC0_0380)); end
        n_tests++; if (bus.im_err !== 1'b0) begin n_fail++; $display("FAIL cancel_err got %b want 0", bus.im_err); end
        n_tests++;
        if (obs_bus_q.size() != 2) begin
            n_fail++; $display("FAIL cancel_bus_count got %0d want 2", obs_bus_q.size());
        end else begin
            o = obs_bus_q.pop_front();
            if (o.addr !== 32'h0000_1000) begin n_fail++; $display("FAIL cancel_old_addr got %h want 00001000", o.addr); end
            o = obs_bus_q.pop_front();
            n_tests++;
            if (o.addr !== 32'hBFC0_0380) begin n_fail++; $display("FAIL cancel_new_addr got %h want bfc00380", o.addr); end
        end
        consume();
    endtask

    task automatic test_rst_mid();
        ack_en = 1'b0;
        bus.dm_addr = 32'h1001_0100; bus.dm_we = 1'b0; bus.dm_req = 1'b1;
        repeat (4) tick();
        n_tests++; if (bus.mem_req !== 1'b1) begin n_fail++; $display("FAIL rst_mid_busy got mem_req=%b want 1", bus.mem_req); end
        rst = 1'b1;
        tick();
        n_tests++; if (bus.mem_req !== 1'b0 || bus.mem_addr !== 32'h0) begin n_fail++; $display("FAIL rst_mid_bus got req=%b addr=%h want 0/0", bus.mem_req, bus.mem_addr); end
        n_tests++; if (bus.dm_stall !== 1'b1 || bus.im_stall !== 1'b0) begin n_fail++; $display("FAIL rst_mid_stall got dm=%b im=%b want 1/0", bus.dm_stall, bus.im_stall); end
        bus.dm_req = 1'b0;
        #1;
        n_tests++; if (bus.dm_stall !== 1'b0) begin n_fail++; $display("FAIL rst_mid_stall_follow got %b want 0", bus.dm_stall); end
        rst = 1'b0;
        tick();
        n_tests++; if (bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL rst_mid_idle got mem_req=%b want 0", bus.mem_req); end
        ack_en = 1'b1;
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_dual();
        test_store();
        test_timeout();
        test_cancel();
        test_rst_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
